// File: rtl/fetch_unit.sv
// Instruction fetch stage: owns the PC, issues word requests over req/gnt/rvalid,
// buffers returned words with their PCs and hands them to decode over valid/ready.
module fetch_unit #(
    parameter logic [31:0] RESET_PC        = 32'h0000_0000,
    parameter int          FIFO_DEPTH      = 2,
    parameter int          MAX_OUTSTANDING = 2
) (
    input  logic        clk,
    input  logic        rst_n,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_gnt,
    input  logic        imem_rvalid,
    input  logic [31:0] imem_rdata,
    output logic        instr_valid,
    input  logic        instr_ready,
    output logic [31:0] instr,
    output logic [31:0] instr_pc,
    input  logic        redirect,
    input  logic [31:0] redirect_pc
);

    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam int CNT_W = $clog2(FIFO_DEPTH + 2);
    localparam logic [CNT_W-1:0] DEPTH_C  = CNT_W'(FIFO_DEPTH);
    localparam logic [CNT_W-1:0] MAX_OS_C = CNT_W'(MAX_OUTSTANDING);
    localparam logic [CNT_W-1:0] ONE_C    = CNT_W'(1);

    typedef enum logic {IDLE, REQ} state_t;

    function automatic logic [31:0] word_align(input logic [31:0] a);
        return a & 32'hFFFF_FFFC;
    endfunction

    state_t             state;
    logic [31:0]        req_addr;
    logic [31:0]        fetch_pc;
    logic [31:0]        resp_pc;
    logic               req_stale;
    logic [CNT_W-1:0]   outstanding;
    logic [CNT_W-1:0]   discard;
    logic [CNT_W-1:0]   fifo_count;
    logic [PTR_W-1:0]   wr_ptr;
    logic [PTR_W-1:0]   rd_ptr;
    logic [31:0]        fifo_instr [FIFO_DEPTH];
    logic [31:0]        fifo_pc    [FIFO_DEPTH];

    logic               gnt_acc;
    logic               rsp_acc;
    logic               push;
    logic               pop;
    logic               idle_credit;
    logic               grant_credit;
    logic [CNT_W-1:0]   os_next;
    logic [31:0]        next_req_addr;

    assign gnt_acc = imem_req && imem_gnt;
    // A response with nothing outstanding is a protocol error and is ignored outright.
    assign rsp_acc = imem_rvalid && (outstanding != '0);
    assign push    = rsp_acc && !redirect && (discard == '0);
    assign pop     = instr_valid && instr_ready;
    assign os_next = outstanding + CNT_W'(gnt_acc) - CNT_W'(rsp_acc);

    assign idle_credit  = ((fifo_count + outstanding) < DEPTH_C) && (outstanding < MAX_OS_C);
    assign grant_credit = ((fifo_count + outstanding + ONE_C) < DEPTH_C)
                          && ((outstanding + ONE_C) < MAX_OS_C);

    // A request that was pending across a redirect must not advance the PC stream.
    assign next_req_addr = req_stale ? fetch_pc : req_addr + 32'd4;

    assign imem_addr = req_addr;

    // ---- request FSM ----
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            imem_req  <= 1'b0;
            req_addr  <= word_align(RESET_PC);
            fetch_pc  <= word_align(RESET_PC);
            req_stale <= 1'b0;
        end else begin
            if (redirect)
                fetch_pc <= word_align(redirect_pc);
            else if (gnt_acc && !req_stale)
                fetch_pc <= req_addr + 32'd4;

            case (state)
                IDLE: begin
                    if (!redirect && idle_credit) begin
                        state    <= REQ;
                        imem_req <= 1'b1;
                        req_addr <= fetch_pc;
                    end
                end
                REQ: begin
                    if (gnt_acc) begin
                        req_stale <= 1'b0;
                        if (!redirect && grant_credit) begin
                            req_addr <= next_req_addr;
                        end else begin
                            state    <= IDLE;
                            imem_req <= 1'b0;
                        end
                    end else if (redirect) begin
                        // Request stays on the bus at the old address; its word is dropped later.
                        req_stale <= 1'b1;
                    end
                end
                default: begin
                    state    <= IDLE;
                    imem_req <= 1'b0;
                end
            endcase
        end
    end

    // ---- response accounting and buffer control ----
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            outstanding <= '0;
            discard     <= '0;
            fifo_count  <= '0;
            wr_ptr      <= '0;
            rd_ptr      <= '0;
            resp_pc     <= word_align(RESET_PC);
        end else begin
            outstanding <= os_next;
            if (redirect) begin
                wr_ptr     <= '0;
                rd_ptr     <= '0;
                fifo_count <= '0;
                discard    <= os_next;
                resp_pc    <= word_align(redirect_pc);
            end else begin
                if (push) begin
                    wr_ptr  <= wr_ptr + PTR_W'(1);
                    resp_pc <= resp_pc + 32'd4;
                end
                if (pop)
                    rd_ptr <= rd_ptr + PTR_W'(1);
                fifo_count <= fifo_count + CNT_W'(push) - CNT_W'(pop);
                discard    <= discard + CNT_W'(gnt_acc && req_stale)
                              - CNT_W'(rsp_acc && (discard != '0));
            end
        end
    end

    // ---- buffer storage ----
    always_ff @(posedge clk) begin
        if (push) begin
            fifo_instr[wr_ptr] <= imem_rdata;
            fifo_pc[wr_ptr]    <= resp_pc;
        end
    end

    assign instr_valid = (fifo_count != '0);
    assign instr       = instr_valid ? fifo_instr[rd_ptr] : 32'h0;
    assign instr_pc    = instr_valid ? fifo_pc[rd_ptr]    : 32'h0;

`ifndef SYNTHESIS
    a_rvalid_without_request: assert property (@(posedge clk) disable iff (!rst_n)
        !(imem_rvalid && (outstanding == '0)));
    a_no_overflow: assert property (@(posedge clk) disable iff (!rst_n)
        !(push && !pop && (fifo_count == DEPTH_C)));
`endif

endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit: a cycle table for the startup stream plus
// hand-written sequences for stalls, redirects and asynchronous reset.
module tb_fetch_unit;

    localparam logic [31:0] RESET_PC = 32'h0000_0000;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_gnt = 1'b0;
    logic        imem_rvalid = 1'b0;
    logic [31:0] imem_rdata = 32'h0;
    logic        instr_valid;
    logic        instr_ready = 1'b0;
    logic [31:0] instr;
    logic [31:0] instr_pc;
    logic        redirect = 1'b0;
    logic [31:0] redirect_pc = 32'h0;

    fetch_unit #(
        .RESET_PC(RESET_PC),
        .FIFO_DEPTH(2),
        .MAX_OUTSTANDING(2)
    ) dut (
        .clk(clk),
        .rst_n(rst_n),
        .imem_req(imem_req),
        .imem_addr(imem_addr),
        .imem_gnt(imem_gnt),
        .imem_rvalid(imem_rvalid),
        .imem_rdata(imem_rdata),
        .instr_valid(instr_valid),
        .instr_ready(instr_ready),
        .instr(instr),
        .instr_pc(instr_pc),
        .redirect(redirect),
        .redirect_pc(redirect_pc)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        gnt;
        logic        ready;
        logic        exp_req;
        logic [31:0] exp_addr;
        logic        exp_valid;
        logic [31:0] exp_pc;
    } vec_t;

    vec_t vecs[10];

    int n_vec = 0;
    int n_err = 0;
    int n_grant = 0;
    int n_pop = 0;

    logic        rst_in = 1'b0;
    logic        gnt_in = 1'b0;
    logic        ready_in = 1'b0;
    logic        redir_in = 1'b0;
    logic [31:0] rpc_in = 32'h0;
    logic        hold = 1'b0;
    logic [31:0] exp_pc = RESET_PC;
    logic [31:0] mq[$];
    logic [31:0] glog[$];
    logic [31:0] stall_addr;

    function automatic logic [31:0] memf(input logic [31:0] a);
        return {a[15:0] ^ 16'hC0DE, a[15:0]};
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h, want %h", name, act, exp);
        end
    endtask

    // Everything happens at the falling edge: memory model, input drive, pop scoreboard.
    task automatic tick();
        @(negedge clk);
        rst_n       = rst_in;
        imem_gnt    = gnt_in;
        instr_ready = ready_in;
        redirect    = redir_in;
        redirect_pc = rpc_in;
        if (!rst_n) begin
            mq.delete();
            imem_rvalid = 1'b0;
            imem_rdata  = 32'h0;
        end else begin
            if (!hold && mq.size() > 0) begin
                imem_rvalid = 1'b1;
                imem_rdata  = memf(mq.pop_front());
            end else begin
                imem_rvalid = 1'b0;
                imem_rdata  = 32'h0;
            end
            if (imem_req && imem_gnt) begin
                mq.push_back(imem_addr);
                glog.push_back(imem_addr);
                n_grant++;
            end
            if (instr_valid && instr_ready) begin
                chk("pop_pc", instr_pc, exp_pc);
                chk("pop_instr", instr, memf(exp_pc));
                exp_pc = exp_pc + 32'd4;
                n_pop++;
            end
            if (redirect)
                exp_pc = redirect_pc & 32'hFFFF_FFFC;
        end
    endtask

    task automatic do_reset();
        rst_in   = 1'b0;
        gnt_in   = 1'b0;
        ready_in = 1'b0;
        redir_in = 1'b0;
        rpc_in   = 32'h0;
        hold     = 1'b0;
        repeat (3) tick();
        exp_pc  = RESET_PC;
        n_grant = 0;
        n_pop   = 0;
        glog.delete();
        rst_in  = 1'b1;
    endtask

    initial begin
        vecs[0] = '{1'b1, 1'b1, 1'b0, 32'h00, 1'b0, 32'h00};
        vecs[1] = '{1'b1, 1'b1, 1'b1, 32'h00, 1'b0, 32'h00};
        vecs[2] = '{1'b1, 1'b1, 1'b1, 32'h04, 1'b0, 32'h00};
        vecs[3] = '{1'b1, 1'b1, 1'b0, 32'h04, 1'b1, 32'h00};
        vecs[4] = '{1'b1, 1'b1, 1'b0, 32'h04, 1'b1, 32'h04};
        vecs[5] = '{1'b1, 1'b1, 1'b1, 32'h08, 1'b0, 32'h00};
        vecs[6] = '{1'b1, 1'b1, 1'b1, 32'h0C, 1'b0, 32'h00};
        vecs[7] = '{1'b1, 1'b1, 1'b0, 32'h0C, 1'b1, 32'h08};
        vecs[8] = '{1'b1, 1'b1, 1'b0, 32'h0C, 1'b1, 32'h0C};
        vecs[9] = '{1'b1, 1'b1, 1'b1, 32'h10, 1'b0, 32'h00};

        // Reset values while rst_n is held low
        do_reset();
        chk("rst_req", 32'(imem_req), 32'd0);
        chk("rst_addr", imem_addr, RESET_PC);
        chk("rst_valid", 32'(instr_valid), 32'd0);
        chk("rst_instr", instr, 32'h0);
        chk("rst_pc", instr_pc, 32'h0);

        // Startup stream, gnt tied high, one-cycle memory, decode always ready
        for (int i = 0; i < 10; i++) begin
            gnt_in   = vecs[i].gnt;
            ready_in = vecs[i].ready;
            tick();
            chk($sformatf("v%0d_req", i), 32'(imem_req), 32'(vecs[i].exp_req));
            chk($sformatf("v%0d_addr", i), imem_addr, vecs[i].exp_addr);
            chk($sformatf("v%0d_valid", i), 32'(instr_valid), 32'(vecs[i].exp_valid));
            chk($sformatf("v%0d_pc", i), instr_pc, vecs[i].exp_pc);
            chk($sformatf("v%0d_instr", i), instr,
                vecs[i].exp_valid ? memf(vecs[i].exp_pc) : 32'h0);
        end

        // Decode stalls: buffer fills to its depth and requesting stops
        ready_in = 1'b0;
        repeat (10) tick();
        chk("stall_req", 32'(imem_req), 32'd0);
        chk("stall_valid", 32'(instr_valid), 32'd1);
        chk("stall_head_pc", instr_pc, 32'h10);
        chk("stall_head_instr", instr, memf(32'h10));
        chk("stall_addr", imem_addr, 32'h14);
        chk("stall_buffered", 32'(n_grant - n_pop), 32'd2);
        ready_in = 1'b1;

        // Memory withholds gnt: request and address stay put
        gnt_in = 1'b0;
        for (int n = 0; n < 20 && !imem_req; n++) tick();
        chk("gstall_wait_req", 32'(imem_req), 32'd1);
        stall_addr = imem_addr;
        chk("gstall_addr", stall_addr, 32'h18);
        for (int n = 0; n < 5; n++) begin
            tick();
            chk($sformatf("gstall_req%0d", n), 32'(imem_req), 32'd1);
            chk($sformatf("gstall_addr%0d", n), imem_addr, stall_addr);
        end
        glog.delete();
        gnt_in = 1'b1;
        for (int n = 0; n < 30 && glog.size() < 2; n++) tick();
        chk("gstall_wait_grants", 32'(glog.size() >= 2), 32'd1);
        if (glog.size() >= 2) begin
            chk("gstall_grant0", glog[0], stall_addr);
            chk("gstall_grant1", glog[1], stall_addr + 32'd4);
        end
        repeat (6) tick();

        // Two responses in flight when a redirect arrives: both dropped
        do_reset();
        hold = 1'b1; gnt_in = 1'b1; ready_in = 1'b1;
        for (int n = 0; n < 20 && mq.size() < 2; n++) tick();
        chk("os2_wait", 32'(mq.size()), 32'd2);
        tick();
        chk("os2_req_blocked", 32'(imem_req), 32'd0);
        glog.delete();
        redir_in = 1'b1; rpc_in = 32'h100;
        tick();
        redir_in = 1'b0; hold = 1'b0;
        tick();
        chk("os2_flushed", 32'(instr_valid), 32'd0);
        for (int n = 0; n < 20 && !instr_valid; n++) tick();
        chk("os2_wait_valid", 32'(instr_valid), 32'd1);
        chk("os2_pc", instr_pc, 32'h100);
        chk("os2_instr", instr, memf(32'h100));
        chk("os2_first_grant", glog.size() > 0 ? glog[0] : 32'hDEAD_BEEF, 32'h100);
        repeat (4) tick();

        // Redirect while a request waits for gnt: old request completes, then target
        do_reset();
        gnt_in = 1'b0; ready_in = 1'b1;
        redir_in = 1'b1; rpc_in = 32'h20;
        tick();
        redir_in = 1'b0;
        for (int n = 0; n < 10 && !imem_req; n++) tick();
        chk("ung_wait_req", 32'(imem_req), 32'd1);
        chk("ung_addr", imem_addr, 32'h20);
        redir_in = 1'b1; rpc_in = 32'h100;
        tick();
        redir_in = 1'b0;
        tick();
        chk("ung_req_held", 32'(imem_req), 32'd1);
        chk("ung_addr_held", imem_addr, 32'h20);
        glog.delete();
        gnt_in = 1'b1;
        for (int n = 0; n < 20 && glog.size() < 2; n++) tick();
        chk("ung_wait_grants", 32'(glog.size() >= 2), 32'd1);
        if (glog.size() >= 2) begin
            chk("ung_grant0", glog[0], 32'h20);
            chk("ung_grant1", glog[1], 32'h100);
        end
        for (int n = 0; n < 20 && !instr_valid; n++) tick();
        chk("ung_pc", instr_pc, 32'h100);
        chk("ung_instr", instr, memf(32'h100));
        repeat (4) tick();

        // Redirect coinciding with a response, unaligned target
        do_reset();
        gnt_in = 1'b1; ready_in = 1'b1;
        for (int n = 0; n < 10 && mq.size() == 0; n++) tick();
        chk("rr_wait_grant", 32'(mq.size() > 0), 32'd1);
        redir_in = 1'b1; rpc_in = 32'h103;
        tick();
        chk("rr_same_cycle", 32'(imem_rvalid && redirect), 32'd1);
        redir_in = 1'b0;
        glog.delete();
        tick();
        chk("rr_flushed", 32'(instr_valid), 32'd0);
        for (int n = 0; n < 20 && glog.size() == 0; n++) tick();
        chk("rr_first_grant", glog.size() > 0 ? glog[0] : 32'hDEAD_BEEF, 32'h100);
        for (int n = 0; n < 20 && !instr_valid; n++) tick();
        chk("rr_pc", instr_pc, 32'h100);
        chk("rr_instr", instr, memf(32'h100));
        repeat (4) tick();

        // Asynchronous reset in the middle of a burst
        do_reset();
        gnt_in = 1'b1; ready_in = 1'b1;
        for (int n = 0; n < 10 && !instr_valid; n++) tick();
        chk("ar_wait_valid", 32'(instr_valid), 32'd1);
        #2;
        rst_in = 1'b0;
        rst_n  = 1'b0;
        #1;
        chk("ar_req", 32'(imem_req), 32'd0);
        chk("ar_addr", imem_addr, RESET_PC);
        chk("ar_valid", 32'(instr_valid), 32'd0);
        chk("ar_instr", instr, 32'h0);
        chk("ar_pc", instr_pc, 32'h0);
        repeat (2) tick();
        exp_pc = RESET_PC;
        glog.delete();
        rst_in = 1'b1;
        for (int n = 0; n < 10 && glog.size() == 0; n++) tick();
        chk("ar_first_grant", glog.size() > 0 ? glog[0] : 32'hDEAD_BEEF, RESET_PC);
        for (int n = 0; n < 10 && !instr_valid; n++) tick();
        chk("ar_first_pc", instr_pc, RESET_PC);
        repeat (6) tick();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
